// File: rtl/inst_mem_slave.sv
// Instruction memory exposed as an AXI4 read-only slave (INCR, 32-bit beats),
// with a host-side preload port that shares the single memory port.
module inst_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_WORDS_LOG2   = 12
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic                          LD_WE,
    input  logic [C_MEM_WORDS_LOG2-1:0]   LD_ADDR,
    input  logic [31:0]                   LD_DATA
);

    localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << C_MEM_WORDS_LOG2;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } state_t;

    state_t                        state_q;
    logic                          arready_q;
    logic                          rvalid_q;
    logic                          rlast_q;
    logic [1:0]                    rresp_q;
    logic [31:0]                   rdata_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [WA_W-1:0]               addr_q;
    logic [7:0]                    cnt_q;
    logic [31:0]                   mem_q [DEPTH];

    logic                          in_range_s;
    logic [31:0]                   rd_word_s;
    logic                          unused_s;

    // The word counter is wider than the memory index, so out-of-range beats never alias into memory.
    assign in_range_s = ((addr_q >> C_MEM_WORDS_LOG2) == {WA_W{1'b0}});
    assign rd_word_s  = mem_q[addr_q[C_MEM_WORDS_LOG2-1:0]];
    assign unused_s   = ^S_AXI_ARADDR[1:0];

    // Host preload port; contents intentionally survive reset.
    always_ff @(posedge ACLK) begin
        if (LD_WE) begin
            mem_q[LD_ADDR] <= LD_DATA;
        end
    end

    // Read-burst FSM with all AXI R-channel outputs registered.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0000_0000;
            rid_q     <= {C_S_AXI_ID_WIDTH{1'b0}};
            addr_q    <= {WA_W{1'b0}};
            cnt_q     <= 8'd0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rid_q     <= S_AXI_ARID;
                        addr_q    <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        cnt_q     <= S_AXI_ARLEN;
                        arready_q <= 1'b0;
                        state_q   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // A preload write owns the memory port this cycle; retry the read next cycle.
                    if (!LD_WE) begin
                        rdata_q  <= in_range_s ? rd_word_s : 32'h0000_0000;
                        rresp_q  <= in_range_s ? 2'b00 : 2'b10;
                        rlast_q  <= (cnt_q == 8'd0);
                        rvalid_q <= 1'b1;
                        state_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= R_IDLE;
                        end else begin
                            addr_q  <= addr_q + {{(WA_W-1){1'b0}}, 1'b1};
                            cnt_q   <= cnt_q - 8'd1;
                            state_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    state_q   <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RID     = rid_q;

endmodule

// File: tb/tb_inst_mem_slave.sv
// Directed bench for inst_mem_slave: latency, bursts with back-pressure,
// out-of-range responses, preload collision and mid-burst reset.
module tb_inst_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        LD_WE;
    logic [11:0] LD_ADDR;
    logic [31:0] LD_DATA;

    int n_chk  = 0;
    int n_fail = 0;

    inst_mem_slave dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .LD_WE         (LD_WE),
        .LD_ADDR       (LD_ADDR),
        .LD_DATA       (LD_DATA)
    );

    // 10 ns clock
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [11:0] a, input logic [31:0] d);
        LD_WE = 1'b1; LD_ADDR = a; LD_DATA = d;
        @(negedge ACLK);
        LD_WE = 1'b0;
    endtask

    // Returns one negedge after the handshake edge (DUT then in R_FETCH).
    task automatic ar(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len);
        S_AXI_ARID = id; S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_rv(input string tag);
        int k = 0;
        while (S_AXI_RVALID !== 1'b1 && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        chk(tag, {31'd0, S_AXI_RVALID}, 32'd1);
    endtask

    task automatic accept();
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    logic [31:0] exp4 [4];

    initial begin
        exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;
        ARESETN = 1'b0; S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 8'd0;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        LD_WE = 1'b0; LD_ADDR = 12'd0; LD_DATA = 32'h0;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        chk("rst_rlast",   {31'd0, S_AXI_RLAST},   32'd0);
        chk("rst_rresp",   {30'd0, S_AXI_RRESP},   32'd0);
        chk("rst_rdata",   S_AXI_RDATA,            32'd0);
        chk("rst_rid",     {31'd0, S_AXI_RID},     32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Single beat, latency N+2
        ld(12'd2, 32'h0050_0093);
        ar(1'b1, 32'h8, 8'd0);
        chk("lat_fetch_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("lat_arready_busy", {31'd0, S_AXI_ARREADY}, 32'd0);
        @(negedge ACLK);
        chk("lat_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("single_rdata", S_AXI_RDATA, 32'h0050_0093);
        chk("single_rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        chk("single_rlast", {31'd0, S_AXI_RLAST}, 32'd1);
        chk("single_rid",   {31'd0, S_AXI_RID},   32'd1);
        accept();
        chk("single_done_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("single_done_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Low address bits ignored
        ar(1'b0, 32'hB, 8'd0);
        wait_rv("unaligned_rv");
        chk("unaligned_rdata", S_AXI_RDATA, 32'h0050_0093);
        accept();

        // 4-beat burst with RREADY toggling
        ld(12'd0, 32'h11); ld(12'd1, 32'h22); ld(12'd2, 32'h33); ld(12'd3, 32'h44);
        ar(1'b0, 32'h0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wait_rv($sformatf("burst_rv%0d", i));
            chk($sformatf("burst_data%0d", i), S_AXI_RDATA, exp4[i]);
            chk($sformatf("burst_last%0d", i), {31'd0, S_AXI_RLAST}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("burst_arready%0d", i), {31'd0, S_AXI_ARREADY}, 32'd0);
            @(negedge ACLK);
            chk($sformatf("burst_hold_rv%0d", i), {31'd0, S_AXI_RVALID}, 32'd1);
            chk($sformatf("burst_hold_data%0d", i), S_AXI_RDATA, exp4[i]);
            accept();
        end
        chk("burst_end_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Out-of-range single beat
        ar(1'b0, 32'h4000, 8'd0);
        wait_rv("oor_rv");
        chk("oor_rresp", {30'd0, S_AXI_RRESP}, 32'd2);
        chk("oor_rdata", S_AXI_RDATA, 32'd0);
        chk("oor_rlast", {31'd0, S_AXI_RLAST}, 32'd1);
        accept();

        // Burst crossing the top of memory
        ld(12'hFFF, 32'hCAFE_F00D);
        ar(1'b0, 32'h3FFC, 8'd1);
        wait_rv("edge_rv0");
        chk("edge_resp0", {30'd0, S_AXI_RRESP}, 32'd0);
        chk("edge_data0", S_AXI_RDATA, 32'hCAFE_F00D);
        chk("edge_last0", {31'd0, S_AXI_RLAST}, 32'd0);
        accept();
        wait_rv("edge_rv1");
        chk("edge_resp1", {30'd0, S_AXI_RRESP}, 32'd2);
        chk("edge_data1", S_AXI_RDATA, 32'd0);
        chk("edge_last1", {31'd0, S_AXI_RLAST}, 32'd1);
        accept();

        // Preload collides with fetch: one-cycle stall, new data returned
        ld(12'd5, 32'hAAAA);
        ar(1'b0, 32'h14, 8'd0);
        LD_WE = 1'b1; LD_ADDR = 12'd5; LD_DATA = 32'hBBBB;
        @(negedge ACLK);
        LD_WE = 1'b0;
        chk("coll_stall_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        @(negedge ACLK);
        chk("coll_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("coll_rdata", S_AXI_RDATA, 32'hBBBB);
        accept();

        // Reset during second beat of a 4-beat burst
        ar(1'b1, 32'h0, 8'd3);
        wait_rv("rst_b0_rv");
        accept();
        wait_rv("rst_b1_rv");
        ARESETN = 1'b0;
        #1;
        chk("async_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("async_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("post_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Fresh burst with RREADY held high: 2 cycles per beat
        S_AXI_RREADY = 1'b1;
        ar(1'b0, 32'h0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk($sformatf("fresh_rv%0d", i), {31'd0, S_AXI_RVALID}, 32'd1);
            chk($sformatf("fresh_data%0d", i), S_AXI_RDATA, exp4[i]);
            chk($sformatf("fresh_last%0d", i), {31'd0, S_AXI_RLAST}, (i == 3) ? 32'd1 : 32'd0);
            @(negedge ACLK);
            chk($sformatf("fresh_gap%0d", i), {31'd0, S_AXI_RVALID}, 32'd0);
        end
        S_AXI_RREADY = 1'b0;
        chk("fresh_end_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_mem_slave.md
INST_MEM_SLAVE -- requirements
Module: inst_mem_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1: width of ARID/RID.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32: byte address width of ARADDR.
REQ-003 SHALL have parameter C_MEM_WORDS_LOG2, default 12: memory holds 2**C_MEM_WORDS_LOG2 32-bit words (16 KiB at default).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as the codebase does:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following ports:
- S_AXI_ARID  in  C_S_AXI_ID_WIDTH  read transaction ID.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  burst start byte address.
- S_AXI_ARLEN  in  8  beats minus 1.
- S_AXI_ARVALID  in  1  address valid.
- S_AXI_ARREADY  out  1  address accepted.
- S_AXI_RID  out  C_S_AXI_ID_WIDTH  echoed ARID.
- S_AXI_RDATA  out  32  read word.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RLAST  out  1  final beat of burst.
- S_AXI_RVALID  out  1  beat valid.
- S_AXI_RREADY  in  1  master accepts beat.
- LD_WE  in  1  host preload write enable.
- LD_ADDR  in  C_MEM_WORDS_LOG2  preload word address.
- LD_DATA  in  32  preload word.

Function
REQ-006 SHALL serve AXI4 read bursts from the fetch master: ARSIZE is fixed at 4 bytes, burst type is INCR only, and no write channels exist.
REQ-007 SHALL implement states R_IDLE, R_FETCH and R_DATA.
REQ-008 SHALL assert ARREADY only in R_IDLE.
REQ-009 On ARVALID&&ARREADY, SHALL:
- latch ARID, word address = ARADDR[C_S_AXI_ADDR_WIDTH-1:2] and beat count = ARLEN;
- move to R_FETCH.
REQ-010 SHALL ignore ARADDR[1:0]; the read is word-aligned.
REQ-011 In R_FETCH, SHALL issue one synchronous memory read of the current word and enter R_DATA on the next cycle, with RVALID=1 and the read word on RDATA.
REQ-012 In R_DATA, SHALL hold RVALID, RDATA, RRESP, RLAST and RID stable until RREADY=1.
REQ-013 On RVALID&&RREADY, SHALL:
- if RLAST, go to R_IDLE;
- else increment the word address by 1, decrement the beat count and go to R_FETCH.
REQ-014 Latency SHALL be: AR handshake at cycle N, first RVALID at N+2, with 2 cycles per beat when RREADY is held high.
REQ-015 SHALL assert RLAST exactly when the beat count equals 0.
REQ-016 SHALL give a beat whose word address is at or above 2**C_MEM_WORDS_LOG2 RRESP=10 and RDATA=0, and SHALL still complete the full burst; the word address counter SHALL be C_S_AXI_ADDR_WIDTH-2 bits and SHALL NOT wrap into memory.
REQ-017 SHALL give in-range beats RRESP=00.
REQ-018 SHALL write LD_DATA to LD_ADDR at the clock edge when LD_WE=1, in any state.
REQ-019 SHALL give LD_WE priority on the single memory port: if LD_WE=1 in R_FETCH, the write completes, the read is not issued, and the block stays in R_FETCH for another cycle.
REQ-020 SHALL return the newly written word when a read follows a write to the same address.
REQ-021 SHALL ignore ARVALID outside R_IDLE; only one burst is outstanding at a time.

Reset
REQ-022 While ARESETN=0, SHALL hold: state=R_IDLE, ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0, RID=0, beat count=0.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset asserted mid-burst SHALL drop RVALID at once (asynchronous) and abandon the burst; no beat is issued after reset release.

Verification
REQ-025 Preload word 2=0x00500093, then AR with ARADDR=0x8, ARLEN=0, ARID=1 -> RVALID two cycles after the handshake, with RDATA=0x00500093, RRESP=00, RLAST=1, RID=1.
REQ-026 Preload words 0-3=0x11,0x22,0x33,0x44, then ARADDR=0x0, ARLEN=3, with RREADY toggling 1/0 -> 4 beats in order, each held stable while RREADY=0, RLAST only on 0x44, ARREADY=0 until after the last beat.
REQ-027 ARADDR=0x4000 with ARLEN=0 at default depth -> RRESP=10, RDATA=0, RLAST=1.
REQ-028 ARADDR=0x3FFC with ARLEN=1 -> beat0 RRESP=00 with the memory word; beat1 RRESP=10 with RDATA=0.
REQ-029 LD_WE=1 to the word under fetch during R_FETCH (old 0xAAAA, new 0xBBBB) -> RVALID one cycle late, RDATA=0xBBBB.
REQ-030 ARESETN=0 during beat 2 of an ARLEN=3 burst -> RVALID=0 immediately; after release ARREADY=1, and a fresh ARADDR=0x0 burst completes correctly.
